// File: rtl/trng_postproc_pkg.sv
// rtl/trng_postproc_pkg.sv - shared types, defaults and helpers for the TRNG conditioning path
package trng_postproc_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_SAMPLE_DIV = 16;
    localparam int DEF_RCT_LIMIT  = 32;

    typedef enum logic {
        VN_FIRST  = 1'b0,
        VN_SECOND = 1'b1
    } vn_state_t;

    // Counter width that stays at least one bit for a modulus of 1
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trng_vn_debias.sv
// rtl/trng_vn_debias.sv - raw-bit synchroniser, sample strobe and von Neumann extractor
module trng_vn_debias
    import trng_postproc_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic rnd_raw,
    output logic bit_valid,
    output logic bit_val,
    output logic sample_valid,
    output logic sample_val
);

    localparam int              CNT_W    = cnt_width(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic             strobe;
    vn_state_t        state;
    vn_state_t        state_next;
    logic             first_q;
    logic             first_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= rnd_raw;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!ena || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign strobe       = ena && (cnt == CNT_LAST);
    assign sample_valid = strobe;
    assign sample_val   = sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= VN_FIRST;
            first_q <= 1'b0;
        end else begin
            state   <= state_next;
            first_q <= first_next;
        end
    end

    // Pair 10 yields 1, pair 01 yields 0, equal pairs are discarded
    always_comb begin
        state_next = state;
        first_next = first_q;
        bit_valid  = 1'b0;
        bit_val    = first_q;
        if (!ena) begin
            state_next = VN_FIRST;
        end else if (strobe) begin
            case (state)
                VN_FIRST: begin
                    first_next = sync_q2;
                    state_next = VN_SECOND;
                end
                VN_SECOND: begin
                    bit_valid  = (first_q != sync_q2);
                    state_next = VN_FIRST;
                end
                default: state_next = VN_FIRST;
            endcase
        end
    end

endmodule

// File: rtl/trng_postproc.sv
// rtl/trng_postproc.sv - TRNG conditioning top: packer, output handshake and repetition-count health test
module trng_postproc
    import trng_postproc_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int RCT_LIMIT  = DEF_RCT_LIMIT,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              rnd_raw,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overflow,
    output logic              health_fail
);

    localparam int               BIT_W     = cnt_width(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam int               RUN_W     = $clog2(RCT_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(RCT_LIMIT);

    logic              bit_valid;
    logic              bit_val;
    logic              sample_valid;
    logic              sample_val;
    logic [DATA_W-1:0] shreg;
    logic [BIT_W-1:0]  bitcnt;
    logic              word_done;
    logic [DATA_W-1:0] word;
    logic              load;
    logic              drop_ovf;
    logic [RUN_W-1:0]  runcnt;
    logic [RUN_W-1:0]  run_next;
    logic              prev_s;
    logic              prev_valid;
    logic              trip;

    trng_vn_debias #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_debias (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .rnd_raw     (rnd_raw),
        .bit_valid   (bit_valid),
        .bit_val     (bit_val),
        .sample_valid(sample_valid),
        .sample_val  (sample_val)
    );

    assign word_done = bit_valid && (bitcnt == BIT_LAST);
    assign word      = {shreg[DATA_W-2:0], bit_val};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (!ena) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (bit_valid) begin
            shreg  <= word;
            bitcnt <= word_done ? '0 : bitcnt + 1'b1;
        end
    end

    always_comb begin
        run_next = RUN_W'(1);
        if (prev_valid && (sample_val == prev_s)) begin
            run_next = (runcnt == RUN_LIMIT) ? runcnt : runcnt + 1'b1;
        end
    end

    assign trip = sample_valid && (run_next == RUN_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runcnt     <= '0;
            prev_s     <= 1'b0;
            prev_valid <= 1'b0;
        end else if (!ena) begin
            runcnt     <= '0;
            prev_s     <= 1'b0;
            prev_valid <= 1'b0;
        end else if (sample_valid) begin
            runcnt     <= run_next;
            prev_s     <= sample_val;
            prev_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            health_fail <= 1'b0;
        end else if (trip) begin
            health_fail <= 1'b1;
        end
    end

    // A failed source silently drops words; only a healthy drop counts as overflow
    assign load     = word_done && !health_fail && (!data_valid || data_ready);
    assign drop_ovf = word_done && !health_fail && data_valid && !data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (load) begin
                data_out   <= word;
                data_valid <= 1'b1;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
            if (drop_ovf) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trng_postproc.sv
// tb/tb_trng_postproc.sv - scoreboard bench for trng_postproc at SAMPLE_DIV 1 and 4
module tb_trng_postproc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena1, raw1, rdy1;
    logic       ena4, raw4, rdy4;
    logic [7:0] d1, d4;
    logic       v1, v4, ov1, ov4, hf1, hf4;

    int         n_vec = 0;
    int         n_err = 0;
    int         vcycles1 = 0;
    int         vcycles4 = 0;
    int         vc;
    logic [7:0] exp1[$];
    logic [7:0] exp4[$];

    always #5 clk = ~clk;

    trng_postproc #(.SAMPLE_DIV(1), .RCT_LIMIT(32), .DATA_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena1), .rnd_raw(raw1),
        .data_out(d1), .data_valid(v1), .data_ready(rdy1),
        .overflow(ov1), .health_fail(hf1)
    );

    trng_postproc #(.SAMPLE_DIV(4), .RCT_LIMIT(32), .DATA_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .rnd_raw(raw4),
        .data_out(d4), .data_valid(v4), .data_ready(rdy4),
        .overflow(ov4), .health_fail(hf4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One sample per cycle; ena rises so the first strobe sees bit 0 through the synchroniser
    task automatic run_bits(input logic [63:0] pat, input int n, input bit drop);
        for (int i = 0; i < n; i++) begin
            raw1 = pat[n-1-i];
            if (i == 2) ena1 = 1'b1;
            tick();
        end
        if (drop) begin
            tick(2);
            ena1 = 1'b0;
        end
    endtask

    task automatic run_bits4(input logic [63:0] pat, input int n);
        ena4 = 1'b1;
        for (int i = 0; i < n; i++) begin
            raw4 = pat[n-1-i];
            tick(4);
        end
        ena4 = 1'b0;
    endtask

    logic       p1_hold = 1'b0, p4_hold = 1'b0;
    logic [7:0] p1_data, p4_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            p1_hold = 1'b0;
        end else begin
            if (p1_hold && v1) check("dut1_stable", d1, p1_data);
            if (v1 && rdy1) begin
                if (exp1.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dut1_unexpected_word: got %0h expected none", d1);
                end else begin
                    check("dut1_word", d1, exp1.pop_front());
                end
            end
            if (v1) vcycles1++;
            p1_hold = v1 && !rdy1;
            p1_data = d1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            p4_hold = 1'b0;
        end else begin
            if (p4_hold && v4) check("dut4_stable", d4, p4_data);
            if (v4 && rdy4) begin
                if (exp4.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dut4_unexpected_word: got %0h expected none", d4);
                end else begin
                    check("dut4_word", d4, exp4.pop_front());
                end
            end
            if (v4) vcycles4++;
            p4_hold = v4 && !rdy4;
            p4_data = d4;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ena1 = 1'b0; raw1 = 1'b0; rdy1 = 1'b1;
        ena4 = 1'b0; raw4 = 1'b0; rdy4 = 1'b1;
        tick(3);
        check("reset_data_out", d1, 8'h00);
        check("reset_data_valid", v1, 0);
        check("reset_overflow", ov1, 0);
        check("reset_health_fail", hf1, 0);
        rst_n = 1'b1;
        tick(2);

        // plain 0xA5 word
        vc = vcycles1;
        exp1.push_back(8'hA5);
        run_bits(64'h9966, 16, 1);
        tick(3);
        check("t1_valid_cycles", vcycles1 - vc, 1);
        check("t1_queue_drained", exp1.size(), 0);
        check("t1_overflow", ov1, 0);
        check("t1_health_fail", hf1, 0);

        // 11 and 00 pairs interleaved must not add bits
        vc = vcycles1;
        exp1.push_back(8'hA5);
        run_bits(64'hB49D86, 24, 1);
        tick(3);
        check("t2_valid_cycles", vcycles1 - vc, 1);
        check("t2_queue_drained", exp1.size(), 0);

        // SAMPLE_DIV=4: five zero bits then ena low flushes them
        vc = vcycles4;
        exp4.push_back(8'hFF);
        run_bits4(64'h155, 10);
        tick(3);
        run_bits4(64'hAAAA, 16);
        tick(3);
        check("flush_valid_cycles", vcycles4 - vc, 1);
        check("flush_queue_drained", exp4.size(), 0);
        check("flush_overflow", ov4, 0);

        // stuck-at-0 source trips on the 32nd sample
        raw1 = 1'b0;
        tick(3);
        ena1 = 1'b1;
        tick(31);
        check("rct_before_limit", hf1, 0);
        tick();
        check("rct_at_limit", hf1, 1);
        check("rct_data_valid", v1, 0);
        check("rct_overflow", ov1, 0);
        ena1 = 1'b0;
        tick(2);
        vc = vcycles1;
        run_bits(64'h9966, 16, 1);
        tick(3);
        check("rct_word_blocked", vcycles1 - vc, 0);
        check("rct_no_overflow", ov1, 0);
        check("rct_sticky", hf1, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rct_cleared_by_reset", hf1, 0);
        tick(2);

        // backpressure: second and third words are discarded
        rdy1 = 1'b0;
        exp1.push_back(8'hA5);
        run_bits(64'h9966_9966_5555, 48, 1);
        tick(2);
        check("bp_data_out", d1, 8'hA5);
        check("bp_data_valid", v1, 1);
        check("bp_overflow", ov1, 1);
        rdy1 = 1'b1;
        tick(3);
        check("bp_drained_valid", v1, 0);
        check("bp_queue_drained", exp1.size(), 0);
        check("bp_overflow_sticky", ov1, 1);

        // async reset while a word is held
        rdy1 = 1'b0;
        exp1.push_back(8'hA5);
        run_bits(64'h9966, 16, 1);
        tick(2);
        check("rst_pre_valid", v1, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_data_out", d1, 8'h00);
        check("rst_async_valid", v1, 0);
        check("rst_async_overflow", ov1, 0);
        check("rst_async_health", hf1, 0);
        exp1.delete();
        tick();
        rst_n = 1'b1;
        rdy1 = 1'b1;

        // async reset mid-word; next word must carry no stale bits
        run_bits(64'h2A, 6, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", v1, 0);
        ena1 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(3);
        vc = vcycles1;
        exp1.push_back(8'h3C);
        run_bits(64'h5AA5, 16, 1);
        tick(3);
        check("rst_mid_valid_cycles", vcycles1 - vc, 1);
        check("rst_mid_queue_drained", exp1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
